rob_allocator: RTL and testbench

- In-order ROB number allocator on the dispatch side of the reorder buffer. Producer end of the ROB-entry interface that the complete/retire stage consumes.
- Hands out up to two ROB numbers per cycle to the two dispatch slots.
- Reclaims entries when the retire side reports up to two in-order retirements per cycle.
- Provides full/empty/occupancy back-pressure to dispatch, and flags protocol violations from the retire side.

---
 rtl/rob_allocator_if.sv | 24 ++
 rtl/rob_allocator.sv | 55 +++++
 tb/tb_rob_allocator.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/rob_allocator_if.sv
// rob_allocator_if: dispatch and retire handshake bundle between the ROB allocator and its environment.
interface rob_allocator_if #(parameter int IDX_W = 4);
    logic             i_flush;
    logic [1:0]       i_dispatch_valid;
    logic             o_dispatch_ready;
    logic [1:0]       o_alloc_fire;
    logic [IDX_W-1:0] o_rob_num0;
    logic [IDX_W-1:0] o_rob_num1;
    logic [1:0]       i_retire_valid;
    logic [IDX_W-1:0] i_retire_rob_num0;
    logic [IDX_W-1:0] i_retire_rob_num1;
    logic [IDX_W:0]   o_count;
    logic             o_full;
    logic             o_empty;
    logic             o_retire_err;
    modport master (
        input  i_flush, i_dispatch_valid, i_retire_valid, i_retire_rob_num0, i_retire_rob_num1,
        output o_dispatch_ready, o_alloc_fire, o_rob_num0, o_rob_num1, o_count, o_full, o_empty, o_retire_err
    );
    modport slave (
        output i_flush, i_dispatch_valid, i_retire_valid, i_retire_rob_num0, i_retire_rob_num1,
        input  o_dispatch_ready, o_alloc_fire, o_rob_num0, o_rob_num1, o_count, o_full, o_empty, o_retire_err
    );
endinterface

// File: rtl/rob_allocator.sv
// rob_allocator: in-order dual-issue ROB number allocator with checked dual retirement and flush.
module rob_allocator #(
    parameter int ROB_DEPTH = 16,
    parameter int IDX_W     = 4
) (
    input logic             i_clk,
    input logic             i_rst,
    rob_allocator_if.master bus
);
    logic [IDX_W-1:0] r_head, r_tail;
    logic [IDX_W:0]   r_count;
    logic             r_err;
    logic [1:0]       w_fire;
    logic             w_ready, w_ret0, w_ret1, w_bad;
    logic [IDX_W-1:0] w_head1;
    logic [IDX_W:0]   w_nalloc, w_nret;
    always_comb begin
        w_ready  = !bus.i_flush && (r_count <= (IDX_W+1)'(ROB_DEPTH - 2));
        w_fire   = bus.i_dispatch_valid & {2{w_ready}};
        w_head1  = r_head + 1'b1;
        w_ret0   = bus.i_retire_valid[0] && (r_count >= 1) && (bus.i_retire_rob_num0 == r_head);
        w_ret1   = w_ret0 && bus.i_retire_valid[1] && (r_count >= 2) && (bus.i_retire_rob_num1 == w_head1);
        // slot1 notice is illegal whenever it is not itself legal, which also covers a bad slot0
        w_bad    = !bus.i_flush && ((bus.i_retire_valid[0] && !w_ret0) || (bus.i_retire_valid[1] && !w_ret1));
        w_nalloc = (IDX_W+1)'(w_fire[0]) + (IDX_W+1)'(w_fire[1]);
        w_nret   = (IDX_W+1)'(w_ret0) + (IDX_W+1)'(w_ret1);
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= r_err | w_bad;
            if (bus.i_flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                r_head  <= r_head + IDX_W'(w_nret);
                r_tail  <= r_tail + IDX_W'(w_nalloc);
                r_count <= r_count + w_nalloc - w_nret;
            end
        end
    end
    assign bus.o_dispatch_ready = w_ready;
    assign bus.o_alloc_fire     = w_fire;
    assign bus.o_rob_num0       = r_tail;
    assign bus.o_rob_num1       = bus.i_dispatch_valid[0] ? r_tail + 1'b1 : r_tail;
    assign bus.o_count          = r_count;
    assign bus.o_full           = r_count == (IDX_W+1)'(ROB_DEPTH);
    assign bus.o_empty          = r_count == '0;
    assign bus.o_retire_err     = r_err;
endmodule

// File: tb/tb_rob_allocator.sv
// tb_rob_allocator: directed vectors with hand-computed expectations for rob_allocator.
module tb_rob_allocator;
    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    rob_allocator_if #(.IDX_W(4)) bus ();
    rob_allocator #(.ROB_DEPTH(16), .IDX_W(4)) dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));
    always #5 i_clk = ~i_clk;
    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic drive(input logic [1:0] dv, input logic [1:0] rv, input int rn0, input int rn1, input logic fl);
        bus.i_dispatch_valid  = dv;
        bus.i_retire_valid    = rv;
        bus.i_retire_rob_num0 = 4'(rn0);
        bus.i_retire_rob_num1 = 4'(rn1);
        bus.i_flush           = fl;
        #1;
    endtask
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask
    task automatic idle_tick();
        tick();
        drive(2'b00, 2'b00, 0, 0, 1'b0);
    endtask
    initial begin
        drive(2'b00, 2'b00, 0, 0, 1'b0);
        chk("rst_count", int'(bus.o_count), 0);
        chk("rst_empty", int'(bus.o_empty), 1);
        chk("rst_full", int'(bus.o_full), 0);
        chk("rst_err", int'(bus.o_retire_err), 0);
        chk("rst_ready", int'(bus.o_dispatch_ready), 1);
        tick();
        i_rst = 1'b0;
        // fill: seven pairs then the last pair reaching full
        for (int i = 0; i < 8; i++) begin
            drive(2'b11, 2'b00, 0, 0, 1'b0);
            chk("fill_num0", int'(bus.o_rob_num0), 2 * i);
            chk("fill_num1", int'(bus.o_rob_num1), 2 * i + 1);
            chk("fill_fire", int'(bus.o_alloc_fire), 3);
            tick();
            chk("fill_count", int'(bus.o_count), 2 * i + 2);
        end
        chk("full_flag", int'(bus.o_full), 1);
        chk("full_ready", int'(bus.o_dispatch_ready), 0);
        chk("full_fire", int'(bus.o_alloc_fire), 0);
        // retire while full: no same-cycle ready bypass, then wrap allocation
        drive(2'b00, 2'b11, 0, 1, 1'b0);
        chk("ret_nobypass", int'(bus.o_dispatch_ready), 0);
        idle_tick();
        chk("ret_count", int'(bus.o_count), 14);
        chk("ret_ready", int'(bus.o_dispatch_ready), 1);
        drive(2'b11, 2'b00, 0, 0, 1'b0);
        chk("wrap_num0", int'(bus.o_rob_num0), 0);
        chk("wrap_num1", int'(bus.o_rob_num1), 1);
        idle_tick();
        drive(2'b00, 2'b11, 2, 3, 1'b0);
        idle_tick();
        chk("head2_count", int'(bus.o_count), 14);
        chk("head2_err", int'(bus.o_retire_err), 0);
        drive(2'b00, 2'b00, 0, 0, 1'b1);
        idle_tick();
        chk("flush_empty", int'(bus.o_empty), 1);
        // lone slot1 compacts onto tail
        drive(2'b10, 2'b00, 0, 0, 1'b0);
        chk("lone1_num1", int'(bus.o_rob_num1), 0);
        chk("lone1_fire", int'(bus.o_alloc_fire), 2);
        idle_tick();
        drive(2'b01, 2'b00, 0, 0, 1'b0);
        chk("lone0_num0", int'(bus.o_rob_num0), 1);
        chk("lone0_fire", int'(bus.o_alloc_fire), 1);
        idle_tick();
        chk("lone_count", int'(bus.o_count), 2);
        chk("lone_err", int'(bus.o_retire_err), 0);
        // retire protocol checking with entries 0..3 live
        drive(2'b00, 2'b00, 0, 0, 1'b1);
        idle_tick();
        drive(2'b11, 2'b00, 0, 0, 1'b0);
        tick();
        idle_tick();
        chk("live4_count", int'(bus.o_count), 4);
        drive(2'b00, 2'b01, 1, 0, 1'b0);
        idle_tick();
        chk("badnum_err", int'(bus.o_retire_err), 1);
        chk("badnum_count", int'(bus.o_count), 4);
        drive(2'b00, 2'b10, 0, 1, 1'b0);
        idle_tick();
        chk("slot1only_count", int'(bus.o_count), 4);
        drive(2'b00, 2'b11, 0, 1, 1'b0);
        idle_tick();
        chk("pair_count", int'(bus.o_count), 2);
        chk("pair_err", int'(bus.o_retire_err), 1);
        drive(2'b00, 2'b01, 2, 0, 1'b0);
        idle_tick();
        chk("head2_retire", int'(bus.o_count), 1);
        // flush with 10 live entries overrides dispatch and retire
        drive(2'b00, 2'b00, 0, 0, 1'b1);
        idle_tick();
        for (int i = 0; i < 5; i++) begin
            drive(2'b11, 2'b00, 0, 0, 1'b0);
            tick();
        end
        drive(2'b00, 2'b00, 0, 0, 1'b0);
        chk("live10_count", int'(bus.o_count), 10);
        drive(2'b11, 2'b01, 0, 0, 1'b1);
        chk("flush_fire", int'(bus.o_alloc_fire), 0);
        chk("flush_ready", int'(bus.o_dispatch_ready), 0);
        idle_tick();
        chk("flush_count", int'(bus.o_count), 0);
        chk("flush_empty2", int'(bus.o_empty), 1);
        chk("flush_keeps_err", int'(bus.o_retire_err), 1);
        drive(2'b11, 2'b00, 0, 0, 1'b0);
        chk("postflush_num0", int'(bus.o_rob_num0), 0);
        chk("postflush_num1", int'(bus.o_rob_num1), 1);
        tick();
        // build count 9 and reset between edges
        tick();
        tick();
        tick();
        drive(2'b01, 2'b00, 0, 0, 1'b0);
        idle_tick();
        chk("pre_rst_count", int'(bus.o_count), 9);
        #2;
        i_rst = 1'b1;
        #1;
        chk("async_count", int'(bus.o_count), 0);
        chk("async_empty", int'(bus.o_empty), 1);
        chk("async_err", int'(bus.o_retire_err), 0);
        chk("async_ready", int'(bus.o_dispatch_ready), 1);
        tick();
        i_rst = 1'b0;
        drive(2'b11, 2'b00, 0, 0, 1'b0);
        chk("after_rst_num0", int'(bus.o_rob_num0), 0);
        chk("after_rst_num1", int'(bus.o_rob_num1), 1);
        idle_tick();
        chk("after_rst_count", int'(bus.o_count), 2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
